// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the streaming FFT core: packs samples into N-point sink frames,
// follows the core's output frame and reports the largest non-DC bin of each frame.
module fft_frame_ctrl #(
    parameter int LOG2_N = 10,
    parameter int DATA_W = 12,
    parameter int AMP_W  = 25,
    parameter int OVR_W  = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     start,
    input  logic                     cont_mode,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic                     sink_ready,
    output logic                     sink_valid,
    output logic                     sink_sop,
    output logic                     sink_eop,
    output logic signed [DATA_W-1:0] sink_real,
    input  logic                     source_valid,
    input  logic                     source_sop,
    input  logic                     source_eop,
    input  logic signed [AMP_W-1:0]  amp,
    output logic                     busy,
    output logic                     peak_valid,
    output logic [LOG2_N-1:0]        peak_bin,
    output logic signed [AMP_W-1:0]  peak_amp,
    output logic                     sync_err,
    output logic [OVR_W-1:0]         ovr_cnt
);

    localparam logic [LOG2_N-1:0] IDX_LAST = {LOG2_N{1'b1}};

    typedef enum logic [1:0] {IDLE, LOAD, UNLOAD, DONE} state_t;

    state_t                    state, state_nxt;
    logic [LOG2_N-1:0]         k;
    logic [LOG2_N-1:0]         ld_k;
    logic                      all_loaded;
    logic [LOG2_N-1:0]         bin;
    logic [LOG2_N-1:0]         max_bin;
    logic signed [AMP_W-1:0]   max_amp;

    logic xfer, can_load, load, drop, beat, frame_end, cand, upd, frame_bad;

    assign xfer      = sink_valid & sink_ready;
    assign can_load  = (state == LOAD) & ~all_loaded & (~sink_valid | sink_ready);
    assign load      = sample_valid & can_load;
    assign drop      = sample_valid & (((state == LOAD) & ~can_load) |
                                       (((state == UNLOAD) | (state == DONE)) & cont_mode));
    assign beat      = (state == UNLOAD) & source_valid;
    assign frame_end = beat & source_eop;
    // Only bins 1..N/2-1 compete: DC and the mirrored upper half carry no new information.
    assign cand      = (bin != '0) & ~bin[LOG2_N-1];
    assign upd       = beat & cand & (amp > max_amp);
    assign frame_bad = (source_sop & (bin != '0)) | (~source_sop & (bin == '0)) |
                       (source_eop & (bin != IDX_LAST));
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (xfer && k == IDX_LAST) state_nxt = UNLOAD;
            UNLOAD:  if (frame_end) state_nxt = DONE;
            DONE:    state_nxt = cont_mode ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            sink_real  <= '0;
            k          <= '0;
            ld_k       <= '0;
            all_loaded <= 1'b0;
            bin        <= '0;
            max_bin    <= '0;
            max_amp    <= '0;
            peak_valid <= 1'b0;
            peak_bin   <= '0;
            peak_amp   <= '0;
            sync_err   <= 1'b0;
            ovr_cnt    <= '0;
        end else begin
            state <= state_nxt;

            // The sop/eop flags follow the sample, so they stay stable while stalled.
            if (load) begin
                sink_valid <= 1'b1;
                sink_real  <= sample_in;
                sink_sop   <= (ld_k == '0);
                sink_eop   <= (ld_k == IDX_LAST);
                ld_k       <= ld_k + 1'b1;
                if (ld_k == IDX_LAST) all_loaded <= 1'b1;
            end else if (xfer) begin
                sink_valid <= 1'b0;
            end
            if (xfer) k <= k + 1'b1;

            if (state_nxt == LOAD && state != LOAD) begin
                k          <= '0;
                ld_k       <= '0;
                all_loaded <= 1'b0;
            end

            if (drop && ovr_cnt != {OVR_W{1'b1}}) ovr_cnt <= ovr_cnt + 1'b1;

            if (state == LOAD && state_nxt == UNLOAD) begin
                bin     <= '0;
                max_bin <= '0;
                max_amp <= '0;
            end
            if (beat) begin
                bin <= bin + 1'b1;
                if (frame_bad) sync_err <= 1'b1;
                if (upd) begin
                    max_amp <= amp;
                    max_bin <= bin;
                end
            end

            peak_valid <= frame_end;
            if (frame_end) begin
                peak_bin <= upd ? bin : max_bin;
                peak_amp <= upd ? amp : max_amp;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl with a 16-point frame: directed sink/source traffic,
// expected transfers and peak reports queued by the stimulus and checked by a monitor.
module tb_fft_frame_ctrl;

    localparam int LOG2_N = 4;
    localparam int DATA_W = 12;
    localparam int AMP_W  = 25;
    localparam int OVR_W  = 8;
    localparam int N      = 16;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst;
    logic                     start;
    logic                     cont_mode;
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_valid;
    logic                     sink_ready;
    logic                     sink_valid;
    logic                     sink_sop;
    logic                     sink_eop;
    logic signed [DATA_W-1:0] sink_real;
    logic                     source_valid;
    logic                     source_sop;
    logic                     source_eop;
    logic signed [AMP_W-1:0]  amp;
    logic                     busy;
    logic                     peak_valid;
    logic [LOG2_N-1:0]        peak_bin;
    logic signed [AMP_W-1:0]  peak_amp;
    logic                     sync_err;
    logic [OVR_W-1:0]         ovr_cnt;

    fft_frame_ctrl #(.LOG2_N(LOG2_N), .DATA_W(DATA_W), .AMP_W(AMP_W), .OVR_W(OVR_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .cont_mode(cont_mode),
        .sample_in(sample_in), .sample_valid(sample_valid), .sink_ready(sink_ready),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_real(sink_real), .source_valid(source_valid), .source_sop(source_sop),
        .source_eop(source_eop), .amp(amp), .busy(busy), .peak_valid(peak_valid),
        .peak_bin(peak_bin), .peak_amp(peak_amp), .sync_err(sync_err), .ovr_cnt(ovr_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { int val; bit sop; bit eop; } sink_exp_t;
    typedef struct { int bin; int amp; } peak_exp_t;

    sink_exp_t sink_q[$];
    peak_exp_t peak_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Transfers seen by the core and peak reports are matched in order against the queues.
    always @(negedge sys_clk) begin
        if (sink_valid && sink_ready) begin
            if (sink_q.size() == 0) begin
                chk("sink_unexpected", int'(sink_real), -9999);
            end else begin
                sink_exp_t e;
                e = sink_q.pop_front();
                chk("sink_real", int'(sink_real), e.val);
                chk("sink_sop", sink_sop, e.sop);
                chk("sink_eop", sink_eop, e.eop);
            end
        end
        if (peak_valid) begin
            if (peak_q.size() == 0) begin
                chk("peak_unexpected", peak_bin, -1);
            end else begin
                peak_exp_t p;
                p = peak_q.pop_front();
                chk("peak_bin", peak_bin, p.bin);
                chk("peak_amp", peak_amp, p.amp);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // One full frame: sample value base+c offered every cycle, core stalled for
    // stall_len cycles right after it has been handed sample index stall_at.
    task automatic load_frame(input int base, input int stall_at, input int stall_len);
        for (int i = 0; i < N; i++) begin
            sink_exp_t e;
            e.val = base + ((i <= stall_at) ? i : i + stall_len);
            e.sop = (i == 0);
            e.eop = (i == N - 1);
            sink_q.push_back(e);
        end
        for (int c = 0; c <= N + stall_len; c++) begin
            sample_valid = (c < N + stall_len);
            sample_in    = DATA_W'(base + c);
            sink_ready   = !(stall_len > 0 && c > stall_at && c <= stall_at + stall_len);
            if (!sink_ready) begin
                chk("stall_hold_real", int'(sink_real), base + stall_at);
                chk("stall_hold_valid", sink_valid, 1);
            end
            step();
        end
        sample_valid = 1'b0;
        chk("unload_busy", busy, 1);
        chk("unload_no_sink", sink_valid, 0);
    endtask

    task automatic stream(input int pat, input int bad_sop, input int exp_bin, input int exp_amp);
        int amps[N];
        peak_exp_t p;
        for (int b = 0; b < N; b++) begin
            case (pat)
                0:       amps[b] = (b == 3) ? 500 : (b == 12) ? 900 : b * 10;
                1:       amps[b] = (b == 2 || b == 6) ? 77 : b;
                default: amps[b] = b * 10;
            endcase
        end
        p.bin = exp_bin;
        p.amp = exp_amp;
        peak_q.push_back(p);
        for (int b = 0; b < N; b++) begin
            source_valid = 1'b1;
            source_sop   = (b == 0) || (b == bad_sop);
            source_eop   = (b == N - 1);
            amp          = AMP_W'(amps[b]);
            step();
        end
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
        chk("peak_valid_done", peak_valid, 1);
        step();
        chk("peak_valid_pulse", peak_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst = 1'b1; start = 1'b0; cont_mode = 1'b0;
        sample_in = '0; sample_valid = 1'b0; sink_ready = 1'b1;
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; amp = '0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_sink_valid", sink_valid, 0);
        chk("rst_peak_valid", peak_valid, 0);
        chk("rst_ovr", ovr_cnt, 0);
        sys_rst = 1'b0;
        step();

        // Plain frame, no backpressure; peak at bin 3, bin 12 is in the mirror half.
        pulse_start();
        load_frame(0, 99, 0);
        stream(0, -1, 3, 500);
        chk("t1_ovr", ovr_cnt, 0);
        chk("t1_sync_err", sync_err, 0);
        chk("t1_idle", busy, 0);

        // Three-cycle stall at k=5 drops three samples; tie between bins 2 and 6.
        pulse_start();
        load_frame(-8, 5, 3);
        chk("t2_ovr", ovr_cnt, 3);
        stream(1, -1, 2, 77);
        chk("t2_sync_err", sync_err, 0);

        // Spurious source_sop at bin 4 flags sync_err but the frame still finishes.
        pulse_start();
        load_frame(40, 99, 0);
        stream(2, 4, 7, 70);
        chk("t3_sync_err", sync_err, 1);

        // Continuous mode: re-arms by itself, sync_err stays sticky.
        cont_mode = 1'b1;
        pulse_start();
        load_frame(200, 99, 0);
        stream(0, -1, 3, 500);
        chk("t4_sync_sticky", sync_err, 1);
        chk("t4_rearmed", busy, 1);

        // Second frame abandoned by reset after seven transfers.
        for (int i = 0; i < 7; i++) begin
            sink_exp_t e;
            e.val = 100 + i;
            e.sop = (i == 0);
            e.eop = 1'b0;
            sink_q.push_back(e);
        end
        for (int c = 0; c < 8; c++) begin
            sample_valid = 1'b1;
            sample_in    = DATA_W'(100 + c);
            sink_ready   = 1'b1;
            step();
        end
        sys_rst = 1'b1; sample_valid = 1'b0; sink_ready = 1'b0;
        step();
        sys_rst = 1'b0;
        chk("rst2_busy", busy, 0);
        chk("rst2_sink_valid", sink_valid, 0);
        chk("rst2_sink_real", int'(sink_real), 0);
        chk("rst2_sop_eop", {sink_sop, sink_eop}, 0);
        chk("rst2_peak", {peak_valid, peak_bin}, 0);
        chk("rst2_peak_amp", peak_amp, 0);
        chk("rst2_sync_err", sync_err, 0);
        chk("rst2_ovr", ovr_cnt, 0);

        // Without a new start the block stays idle even in continuous mode.
        sink_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample_valid = 1'b1;
            sample_in    = DATA_W'(300 + c);
            step();
            chk("idle_no_sink", sink_valid, 0);
        end
        sample_valid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_ovr", ovr_cnt, 0);
        step();

        chk("sink_q_drained", sink_q.size(), 0);
        chk("peak_q_drained", peak_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
